// File: rtl/conv_complex_deconv_if.sv
// Sample stream bundle for conv_complex_deconv: input samples and recovered output samples.
interface conv_complex_deconv_if #(
  parameter int W = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_complex_deconv.sv
// Streaming inverse of a monic 3-tap complex convolution: x[n] = y[n] - h1*x[n-1] - h2*x[n-2].
// Optional residual-sample zero check enabled by defining DECONV_RESIDUAL_CHECK_EN.
module conv_complex_deconv #(
  parameter int QI        = 3,
  parameter int QF        = 3,
  parameter int NUM_ELEMS = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [4*(QI+QF)-1:0]       kernel,
  conv_complex_deconv_if.slave       stream,
  output logic                       overflow,
`ifdef DECONV_RESIDUAL_CHECK_EN
  output logic                       residual_err,
`endif
  output logic                       done
);

  localparam int W    = QI + QF;
  localparam int PW   = 2 * W + 1;
  localparam int SW   = 2 * W + 3;
  localparam int CW   = $clog2(NUM_ELEMS + 3);
  localparam int MAXI = 2 ** (W - 1) - 1;
  localparam int MINI = -(2 ** (W - 1));
  localparam logic [CW-1:0] NOUT = CW'(NUM_ELEMS);
  localparam logic [CW-1:0] FULL = CW'(NUM_ELEMS + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic signed [W-1:0]  h1r, h1i, h2r, h2i;
  logic signed [W-1:0]  x1r, x1i, x2r, x2i;
  logic signed [W-1:0]  yr, yi, xr, xi;
  logic signed [PW-1:0] p1r, p1i, p2r, p2i;
  logic signed [SW-1:0] sr, si;
  logic [CW-1:0]        cnt;
  logic                 ov;
  logic [2*W-1:0]       od;
  logic                 satr, sati, xfer;

  function automatic logic [W:0] sat(input logic signed [SW-1:0] v);
    if (v > SW'(MAXI))
      return {1'b1, W'(MAXI)};
    else if (v < SW'(MINI))
      return {1'b1, W'(MINI)};
    else
      return {1'b0, v[W-1:0]};
  endfunction

  // Full-precision products, floor shift, then per-component saturation.
  always_comb begin
    yr  = stream.in_data[2*W-1:W];
    yi  = stream.in_data[W-1:0];
    p1r = PW'(h1r) * PW'(x1r) - PW'(h1i) * PW'(x1i);
    p1i = PW'(h1r) * PW'(x1i) + PW'(h1i) * PW'(x1r);
    p2r = PW'(h2r) * PW'(x2r) - PW'(h2i) * PW'(x2i);
    p2i = PW'(h2r) * PW'(x2i) + PW'(h2i) * PW'(x2r);
    sr  = (SW'(yr) <<< QF) - SW'(p1r) - SW'(p2r);
    si  = (SW'(yi) <<< QF) - SW'(p1i) - SW'(p2i);
    {satr, xr} = sat(sr >>> QF);
    {sati, xi} = sat(si >>> QF);
  end

  assign stream.in_ready  = (state == RUN) && (!ov || stream.out_ready) && (cnt < FULL);
  assign stream.out_valid = ov;
  assign stream.out_data  = od;
  assign xfer             = stream.in_valid && stream.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      h1r      <= '0;
      h1i      <= '0;
      h2r      <= '0;
      h2i      <= '0;
      x1r      <= '0;
      x1i      <= '0;
      x2r      <= '0;
      x2i      <= '0;
      cnt      <= '0;
      ov       <= 1'b0;
      od       <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
`ifdef DECONV_RESIDUAL_CHECK_EN
      residual_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (en) begin
            {h1r, h1i, h2r, h2i} <= kernel;
            x1r      <= '0;
            x1i      <= '0;
            x2r      <= '0;
            x2i      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
`ifdef DECONV_RESIDUAL_CHECK_EN
            residual_err <= 1'b0;
`endif
            state    <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            x2r <= x1r;
            x2i <= x1i;
            x1r <= xr;
            x1i <= xi;
            cnt <= cnt + 1'b1;
            if (satr || sati)
              overflow <= 1'b1;
`ifdef DECONV_RESIDUAL_CHECK_EN
            if (cnt >= NOUT && (xr != '0 || xi != '0))
              residual_err <= 1'b1;
`endif
          end
          // A residual transfer never loads the output; it may still retire the pending one.
          if (xfer && cnt < NOUT) begin
            od <= {xr, xi};
            ov <= 1'b1;
          end else if (stream.out_ready) begin
            ov <= 1'b0;
          end
          if (cnt == FULL && !ov) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_complex_deconv.sv
// Randomized self-checking bench for conv_complex_deconv against a plain-integer recursion model.
module tb_conv_complex_deconv;
  localparam int QI   = 3;
  localparam int QF   = 3;
  localparam int N    = 4;
  localparam int W    = QI + QF;
  localparam int DW   = 2 * W;
  localparam int KW   = 4 * W;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [KW-1:0] kernel;
  logic          overflow;
  logic          done;
`ifdef DECONV_RESIDUAL_CHECK_EN
  logic          residual_err;
`endif

  conv_complex_deconv_if #(.W(W)) bus ();

  conv_complex_deconv #(.QI(QI), .QF(QF), .NUM_ELEMS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .kernel   (kernel),
    .stream   (bus),
    .overflow (overflow),
`ifdef DECONV_RESIDUAL_CHECK_EN
    .residual_err (residual_err),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int kr[4];
  int yre[N+2];
  int yim[N+2];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, inout bit f);
    if (v > MAXV) begin
      f = 1'b1;
      return MAXV;
    end
    if (v < MINV) begin
      f = 1'b1;
      return MINV;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] pack(input int re, input int im);
    logic [31:0] a;
    logic [31:0] b;
    a = re;
    b = im;
    return {a[W-1:0], b[W-1:0]};
  endfunction

  function automatic logic [KW-1:0] pack_k();
    logic [31:0] a[4];
    for (int i = 0; i < 4; i++) a[i] = kr[i];
    return {a[0][W-1:0], a[1][W-1:0], a[2][W-1:0], a[3][W-1:0]};
  endfunction

  // mode 0: random valid/ready; 1: always valid/ready; 2: ready held low 5 cycles once an output is pending.
  task automatic run_frame(input int mode, input int abort);
    int qr[$];
    int qi[$];
    int m1r = 0, m1i = 0, m2r = 0, m2i = 0;
    int sent = 0, bp = 5, vr, vi, sr, si;
    bit run_m = 1'b1, pend = 1'b0, ovf_m = 1'b0, res_m = 1'b0, fin = 1'b0;
    bit dn, ir, xfer, ohs;

    @(negedge clk);
    en = 1'b1;
    kernel = pack_k();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data = '0;
    #1 check("idle_rdy", bus.in_ready, 0);

    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
      kernel = KW'($urandom);
      case (mode)
        0: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          bus.out_ready = !(qr.size() != 0 && bp > 0);
          if (!bus.out_ready) bp--;
        end
        default: bus.out_ready = 1'b1;
      endcase
      if (sent < N + 2) begin
        bus.in_valid = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.in_data  = pack(yre[sent], yim[sent]);
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = DW'($urandom);
      end
      #1;
      dn = pend;
      pend = 1'b0;
      check("done", done, dn);
      check("ovalid", bus.out_valid, qr.size() != 0);
      if (qr.size() != 0) check("odata", bus.out_data, pack(qr[0], qi[0]));
      ir = run_m && (qr.size() == 0 || bus.out_ready) && sent < N + 2;
      check("irdy", bus.in_ready, ir);
      check("ovf", overflow, ovf_m);
`ifdef DECONV_RESIDUAL_CHECK_EN
      check("resid", residual_err, res_m);
`endif
      if (dn) begin
        fin = 1'b1;
      end else begin
        if (run_m && sent == N + 2 && qr.size() == 0) begin
          pend = 1'b1;
          run_m = 1'b0;
        end
        xfer = bus.in_valid && ir;
        ohs = (qr.size() != 0) && bus.out_ready;
        if (ohs) begin
          void'(qr.pop_front());
          void'(qi.pop_front());
        end
        if (xfer) begin
          sr = yre[sent] * (1 << QF) - (kr[0] * m1r - kr[1] * m1i) - (kr[2] * m2r - kr[3] * m2i);
          si = yim[sent] * (1 << QF) - (kr[0] * m1i + kr[1] * m1r) - (kr[2] * m2i + kr[3] * m2r);
          vr = clamp(sr >>> QF, ovf_m);
          vi = clamp(si >>> QF, ovf_m);
          m2r = m1r;
          m2i = m1i;
          m1r = vr;
          m1i = vi;
          if (sent < N) begin
            qr.push_back(vr);
            qi.push_back(vi);
          end else if (vr != 0 || vi != 0) begin
            res_m = 1'b1;
          end
          sent++;
          if (abort != 0 && sent == abort) fin = 1'b1;
        end
      end
    end
    en = 1'b0;
    check("finished", fin, 1);
  endtask

  task automatic set_identity();
    kr  = '{0, 0, 0, 0};
    yre = '{8, 16, -8, 0, 0, 0};
    yim = '{0, 0, 0, 0, 0, 0};
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    kernel = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ovalid", bus.out_valid, 0);
    check("rst_odata", bus.out_data, 0);
    check("rst_irdy", bus.in_ready, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    set_identity();
    run_frame(1, 0);

    kr  = '{-4, 0, 0, 0};
    yre = '{8, -4, 0, 0, 0, 0};
    run_frame(1, 0);

    kr  = '{-24, 0, 0, 0};
    yre = '{24, 24, 24, 24, 24, 24};
    run_frame(1, 0);
    @(negedge clk);
    #1 check("ovf_hold", overflow, 1);

    set_identity();
    run_frame(2, 0);

    yre = '{8, 16, -8, 0, 0, 8};
    run_frame(1, 0);
    set_identity();
    run_frame(0, 0);

    kr  = '{-24, 0, 0, 0};
    yre = '{24, 24, 24, 24, 24, 24};
    run_frame(1, 2);
    @(negedge clk);
    #1 check("ovf_pre", overflow, 1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    check("mid_ovalid", bus.out_valid, 0);
    check("mid_odata", bus.out_data, 0);
    check("mid_irdy", bus.in_ready, 0);
    check("mid_ovf", overflow, 0);
    check("mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_done", done, 0);
      check("post_irdy", bus.in_ready, 0);
    end
    set_identity();
    run_frame(1, 0);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 4; i++) kr[i] = int'($urandom_range(0, 16)) - 8;
      for (int i = 0; i < N + 2; i++) begin
        yre[i] = int'($urandom_range(0, 63)) - 32;
        yim[i] = int'($urandom_range(0, 63)) - 32;
      end
      run_frame(f % 3, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
